// File: rtl/dff_pipe_if.sv
// Bus interface for dff_pipe: stage-advance control, input data/valid and pipeline status.
// Carries the synchronous clear line when DFF_PIPE_SYNC_CLR_EN is defined.
interface dff_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             en;
  logic [WIDTH-1:0] d;
  logic             d_vld;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] n_q;
  logic             q_vld;
  logic [CW-1:0]    fill_cnt;
  logic             full;
`ifdef DFF_PIPE_SYNC_CLR_EN
  logic             clr;

  modport slave  (input  en, d, d_vld, clr, output q, n_q, q_vld, fill_cnt, full);
  modport master (output en, d, d_vld, clr, input  q, n_q, q_vld, fill_cnt, full);
`else
  modport slave  (input  en, d, d_vld, output q, n_q, q_vld, fill_cnt, full);
  modport master (output en, d, d_vld, input  q, n_q, q_vld, fill_cnt, full);
`endif
endinterface

// File: rtl/dff_pipe.sv
// Enabled DEPTH-stage register pipeline with per-stage valid flags and an occupancy count.
// Optional synchronous clear port enabled by DFF_PIPE_SYNC_CLR_EN.
module dff_pipe #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  dff_pipe_if.slave  bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             sync_clr;

`ifdef DFF_PIPE_SYNC_CLR_EN
  assign sync_clr = bus.clr;
`else
  assign sync_clr = 1'b0;
`endif

  // Next state: clear beats advance; the count tracks only what enters vs. leaves.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    if (sync_clr) begin
      for (int i = 0; i < int'(DEPTH); i++) data_d[i] = RST_VAL;
      vld_d = '0;
      cnt_d = '0;
    end else if (bus.en) begin
      data_d[0] = bus.d;
      vld_d[0]  = bus.d_vld;
      for (int i = 1; i < int'(DEPTH); i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
      if (bus.d_vld && !vld_q[DEPTH-1])      cnt_d = cnt_q + CW'(1);
      else if (!bus.d_vld && vld_q[DEPTH-1]) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= RST_VAL;
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= data_d[i];
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.q        = data_q[DEPTH-1];
  assign bus.n_q      = ~data_q[DEPTH-1];
  assign bus.q_vld    = vld_q[DEPTH-1];
  assign bus.fill_cnt = cnt_q;
  assign bus.full     = (cnt_q == CW'(DEPTH));

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: directed vector table, reset corners and randomized
// traffic against a shift-array model whose occupancy is a plain population count.
module tb_dff_pipe;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  RST_VAL = 8'h00;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RST_VAL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] m_data [DEPTH];
  logic       m_vld  [DEPTH];

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic       v;
    logic [7:0] eq;
    logic       ev;
    int         ecnt;
    logic       ef;
  } vec_t;
  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] eq, input logic ev,
                         input int ecnt, input logic ef);
    logic [7:0] enq;
    enq = ~eq;
    chk({tag, " q"},        32'(bus.q),        32'(eq));
    chk({tag, " n_q"},      32'(bus.n_q),      32'(enq));
    chk({tag, " q_vld"},    32'(bus.q_vld),    32'(ev));
    chk({tag, " fill_cnt"}, 32'(bus.fill_cnt), 32'(ecnt));
    chk({tag, " full"},     32'(bus.full),     32'(ef));
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (m_vld[i]) n++;
    return n;
  endfunction

  task automatic model_rst();
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_data[i] = RST_VAL;
      m_vld[i]  = 1'b0;
    end
  endtask

  task automatic chk_model(input string tag);
    chk_out(tag, m_data[DEPTH-1], m_vld[DEPTH-1], model_cnt(), model_cnt() == int'(DEPTH));
  endtask

  // One clock: drive inputs, take the edge, then advance the model.
  task automatic step(input logic en, input logic [7:0] d, input logic v, input logic clr);
    bus.en    = en;
    bus.d     = d;
    bus.d_vld = v;
`ifdef DFF_PIPE_SYNC_CLR_EN
    bus.clr   = clr;
`endif
    @(posedge clk);
    #1;
    if (clr) model_rst();
    else if (en) begin
      for (int i = int'(DEPTH) - 1; i > 0; i--) begin
        m_data[i] = m_data[i-1];
        m_vld[i]  = m_vld[i-1];
      end
      m_data[0] = d;
      m_vld[0]  = v;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.en    = 1'b0;
    bus.d     = 8'h00;
    bus.d_vld = 1'b0;
`ifdef DFF_PIPE_SYNC_CLR_EN
    bus.clr   = 1'b0;
`endif
    model_rst();

    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 8'h00, 1'b0, 1, 1'b0};
    vecs[1]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1, 1'b0};
    vecs[2]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1, 1'b0};
    vecs[3]  = '{1'b1, 8'h00, 1'b0, 8'hA5, 1'b1, 1, 1'b0};
    vecs[4]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0};
    vecs[5]  = '{1'b1, 8'h01, 1'b1, 8'h00, 1'b0, 1, 1'b0};
    vecs[6]  = '{1'b1, 8'h02, 1'b1, 8'h00, 1'b0, 2, 1'b0};
    vecs[7]  = '{1'b1, 8'h03, 1'b1, 8'h00, 1'b0, 3, 1'b0};
    vecs[8]  = '{1'b1, 8'h04, 1'b1, 8'h01, 1'b1, 4, 1'b1};
    vecs[9]  = '{1'b0, 8'hFF, 1'b1, 8'h01, 1'b1, 4, 1'b1};
    vecs[10] = '{1'b0, 8'hEE, 1'b0, 8'h01, 1'b1, 4, 1'b1};
    vecs[11] = '{1'b0, 8'hDD, 1'b1, 8'h01, 1'b1, 4, 1'b1};
    vecs[12] = '{1'b1, 8'h00, 1'b0, 8'h02, 1'b1, 3, 1'b0};
    vecs[13] = '{1'b1, 8'h00, 1'b0, 8'h03, 1'b1, 2, 1'b0};
    vecs[14] = '{1'b1, 8'h00, 1'b0, 8'h04, 1'b1, 1, 1'b0};
    vecs[15] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0};

    #1;
    chk_out("reset_t0", 8'h00, 1'b0, 0, 1'b0);

    // Clock edges with traffic while reset is held must not disturb anything.
    bus.en    = 1'b1;
    bus.d     = 8'h3C;
    bus.d_vld = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset_hold", 8'h00, 1'b0, 0, 1'b0);
    bus.en = 1'b0;
    rst_n  = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].en, vecs[i].d, vecs[i].v, 1'b0);
      chk_out($sformatf("vec%0d", i), vecs[i].eq, vecs[i].ev, vecs[i].ecnt, vecs[i].ef);
    end

    // Asynchronous reset mid-cycle with two entries in flight.
    step(1'b1, 8'h11, 1'b1, 1'b0);
    step(1'b1, 8'h22, 1'b1, 1'b0);
    chk("pre_rst fill_cnt", 32'(bus.fill_cnt), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 8'h00, 1'b0, 0, 1'b0);
    model_rst();
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("post_rst fill_cnt", 32'(bus.fill_cnt), 32'd1);
    repeat (3) step(1'b1, 8'h00, 1'b0, 1'b0);
    chk_out("post_rst arrive", 8'h77, 1'b1, 1, 1'b0);

`ifdef DFF_PIPE_SYNC_CLR_EN
    repeat (3) step(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("pre_clr fill_cnt", 32'(bus.fill_cnt), 32'd3);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    chk_out("sync_clr", RST_VAL, 1'b0, 0, 1'b0);
`endif

    // Randomized traffic against the model, with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      logic r_clr;
      r_clr = 1'b0;
`ifdef DFF_PIPE_SYNC_CLR_EN
      r_clr = ($urandom_range(0, 15) == 0);
`endif
      step(($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)), r_clr);
      chk_model($sformatf("rand%0d", n));
      if (n % 97 == 96) begin
        #2;
        rst_n = 1'b0;
        model_rst();
        #1;
        chk_model($sformatf("rand_rst%0d", n));
        rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bit width (legal 1..64).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (legal 1..32).
REQ-003 SHALL have parameter RST_VAL, default 0, WIDTH-bit value loaded into every data stage on reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  stage-advance enable.
REQ-007 SHALL have port d  input  WIDTH  data into stage 0.
REQ-008 SHALL have port d_vld  input  1  valid flag accompanying d.
REQ-009 SHALL have port q  output  WIDTH  data of stage DEPTH-1.
REQ-010 SHALL have port n_q  output  WIDTH  bitwise complement of q.
REQ-011 SHALL have port q_vld  output  1  valid flag of stage DEPTH-1.
REQ-012 SHALL have port fill_cnt  output  $clog2(DEPTH+1)  count of stages holding a valid flag.
REQ-013 SHALL have port full  output  1  high when fill_cnt equals DEPTH.

Function
REQ-014 SHALL hold DEPTH data registers and DEPTH valid flags; stage 0 is the input end.
REQ-015 SHALL, on a rising edge with en=1, load stage 0 with d/d_vld and stage i with stage i-1 for i=1..DEPTH-1.
REQ-016 SHALL, on a rising edge with en=0, hold every data register, valid flag and fill_cnt.
REQ-017 SHALL present d on q after exactly DEPTH rising edges with en=1; en=0 edges add no advance.
REQ-018 SHALL drive q, n_q and q_vld directly from stage DEPTH-1 registers (no combinational path from d, d_vld or en).
REQ-019 SHALL drive n_q = ~q at all times, including during reset.
REQ-020 SHALL update fill_cnt on en=1 edges: +1 when d_vld=1 and q_vld=0; -1 when d_vld=0 and q_vld=1; otherwise unchanged.
REQ-021 SHALL keep fill_cnt equal to the population count of the valid flags at every edge; it never exceeds DEPTH or wraps below 0.
REQ-022 SHALL assert full combinationally from fill_cnt==DEPTH; full does not block shifting, and the oldest valid entry leaves via q when en=1.
REQ-023 SHALL, for DEPTH=1, behave as a single enabled D flip-flop with valid flag; fill_cnt is 1 bit.
REQ-024 SHALL shift data registers whether or not the corresponding valid flag is set; invalid stages carry don't-care data.

Reset
REQ-025 SHALL, while rst_n=0, force all data stages to RST_VAL, all valid flags to 0, and fill_cnt to 0, independent of clk.
REQ-026 SHALL therefore give reset outputs q=RST_VAL, n_q=~RST_VAL, q_vld=0, fill_cnt=0, full=0.
REQ-027 SHALL abort in-flight data on reset assertion mid-operation; after deassertion the first en=1 edge loads stage 0 normally.

Configuration
REQ-028 SHALL, when macro DFF_PIPE_SYNC_CLR_EN is defined, add port clr  input  1, a synchronous clear.
REQ-029 SHALL, with DFF_PIPE_SYNC_CLR_EN, on a rising edge with clr=1, load all stages with RST_VAL, clear all valid flags and fill_cnt; clr has priority over en and d.
REQ-030 SHALL, without DFF_PIPE_SYNC_CLR_EN, omit port clr entirely; behaviour is REQ-014..REQ-027 only.

Verification
REQ-031 SHALL verify, WIDTH=8, DEPTH=4, RST_VAL=8'h00, rst_n low at t0: q=8'h00, n_q=8'hFF, q_vld=0, fill_cnt=0, full=0.
REQ-032 SHALL verify: en=1, d=8'hA5, d_vld=1 for one edge, then d_vld=0 -> q=8'hA5, n_q=8'h5A, q_vld=1 after edge 4, q_vld=0 after edge 5.
REQ-033 SHALL verify: en=1, d_vld=1 for 4 edges with d=1,2,3,4 -> full=1, fill_cnt=4; en=0 for 3 edges -> q=1, fill_cnt=4 held.
REQ-034 SHALL verify: pipeline full, en=1, d_vld=0 for 4 edges -> q sequence 2,3,4 with fill_cnt 3,2,1,0 and full=0 after the first edge.
REQ-035 SHALL verify: fill_cnt=2, rst_n pulsed low between edges -> immediate q=RST_VAL, q_vld=0, fill_cnt=0 without a clock edge.
REQ-036 SHALL verify, with DFF_PIPE_SYNC_CLR_EN and fill_cnt=3, clr=1 and en=1, d_vld=1 on one edge -> fill_cnt=0, q_vld=0, q=RST_VAL after that edge.
